// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: presents word addresses to instruction memory, waits MEM_LATENCY cycles,
// then holds the word for decode. Define FETCH_ALIGN_CHECK_EN for sticky redirect-target faults.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 5,
  parameter int          MEM_WORDS   = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
`ifdef FETCH_ALIGN_CHECK_EN
    , FAULT
`endif
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(MEM_LATENCY - 1);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  count;
  logic        halted;
  logic [31:0] redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  logic target_bad;

  assign halted      = (state == FAULT);
  assign target_bad  = (redirect_target[1:0] != 2'b00) || ({1'b0, redirect_target} >= MEM_BYTES);
  assign redirect_pc = redirect_target;
`else
  logic unused_config;

  // Without the checker a misaligned target is silently rounded down to its word.
  assign halted        = 1'b0;
  assign redirect_pc   = {redirect_target[31:2], 2'b00};
  assign fetch_fault   = 1'b0;
  assign unused_config = ^{redirect_target[1:0], MEM_WORDS};
`endif

  // Redirects take priority over every state action, including a completing fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_address <= RESET_PC;
      instr_out    <= '0;
      pc_out       <= '0;
      instr_valid  <= 1'b0;
      count        <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault  <= 1'b0;
`endif
    end else if (halted) begin
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      count       <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (target_bad) begin
        fetch_fault <= 1'b1;
        state       <= FAULT;
      end else begin
        pc    <= redirect_pc;
        state <= IDLE;
      end
`else
      pc    <= redirect_pc;
      state <= IDLE;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fetch_enable) begin
            imem_address <= pc;
            count        <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (count == LAST_COUNT) begin
            instr_out   <= instr_in;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            count       <= '0;
            state       <= HOLD;
          end else begin
            count <= count + 8'd1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: expected fetch PCs are queued as stimulus is driven and
// compared whenever decode accepts a word. Adapts to the FETCH_ALIGN_CHECK_EN build.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam int LATENCY = 5;
  localparam int PERIOD  = LATENCY + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic [31:0] imem_address;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;

  int          vectors     = 0;
  int          miscompares = 0;
  int          accepted    = 0;
  int          extra       = 0;
  int          valid_cycles = 0;
  int          cycle       = 0;
  logic [31:0] exp_q[$];
  int          accept_cycle[$];

  logic [31:0] held_instr, held_pc, held_addr;
  int          changes, edges, saved_vc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h3210_0000 + a;
  endfunction

  assign instr_in = mem_word(imem_address);

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .MEM_LATENCY(LATENCY),
    .MEM_WORDS  (1024)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .imem_address   (imem_address),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Runs at the falling edge with this cycle's inputs already driven, so a valid&&ready
  // seen here is exactly the handshake the next rising edge completes.
  task automatic observe();
    logic [31:0] e;
    if (!reset && instr_valid) valid_cycles++;
    if (!reset && instr_valid && instr_ready) begin
      accepted++;
      accept_cycle.push_back(cycle);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_out", pc_out, e);
        checkOutput("instr_out", instr_out, mem_word(e));
      end else begin
        extra++;
      end
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv,
                               input logic [31:0] rt);
    fetch_enable    = fe;
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    observe();
    @(posedge clock);
    @(negedge clock);
    cycle++;
  endtask

  task automatic doReset(input logic fe);
    reset = 1'b1;
    exp_q.delete();
    accept_cycle.delete();
    accepted     = 0;
    valid_cycles = 0;
    repeat (3) applyStimulus(fe, 1'b1, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic runUntilAccepted(input int n, input logic fe, input int budget);
    int spent;
    spent = 0;
    while (accepted < n && spent < budget) begin
      applyStimulus(fe, 1'b1, 1'b0, 32'h0);
      spent++;
    end
    checkOutput("accept_timeout", 32'(accepted), 32'(n));
  endtask

  task automatic waitValid(input logic fe, input logic rdy, input int budget);
    int spent;
    spent = 0;
    while (!instr_valid && spent < budget) begin
      applyStimulus(fe, rdy, 1'b0, 32'h0);
      spent++;
    end
    checkOutput("valid_timeout", {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    reset           = 1'b1;
    fetch_enable    = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    @(negedge clock);

    // Reset, first-fetch latency and a four-word sequential stream.
    doReset(1'b1);
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset_instr", instr_out, 32'h0);
    checkOutput("reset_addr", imem_address, 32'h0);
    checkOutput("reset_fault", {31'b0, fetch_fault}, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    edges = 0;
    while (!instr_valid && edges < 20) begin
      if (edges > 0) checkOutput("imem_addr_wait", imem_address, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      edges++;
    end
    checkOutput("first_valid_latency", 32'(edges), 32'(LATENCY + 1));
    checkOutput("first_instr", instr_out, 32'h3210_0000);
    checkOutput("first_pc", pc_out, 32'h0);
    runUntilAccepted(4, 1'b1, 60);
    for (int i = 1; i < accept_cycle.size(); i++)
      checkOutput("stream_spacing", 32'(accept_cycle[i] - accept_cycle[i-1]), 32'(PERIOD));
    checkOutput("valid_pulse_cycles", 32'(valid_cycles), 32'd4);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("idle_no_valid", 32'(valid_cycles), 32'd4);

    // Backpressure: word at 0x10 held for ten cycles, then the next fetch is 0x14.
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    waitValid(1'b1, 1'b0, 20);
    held_instr = instr_out;
    held_pc    = pc_out;
    held_addr  = imem_address;
    checkOutput("hold_pc", held_pc, 32'h10);
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (instr_out !== held_instr || pc_out !== held_pc ||
          imem_address !== held_addr || instr_valid !== 1'b1) changes++;
    end
    checkOutput("hold_stable_changes", 32'(changes), 32'd0);
    runUntilAccepted(accepted + 2, 1'b1, 40);
    checkOutput("after_hold_spacing",
                32'(accept_cycle[accept_cycle.size()-1] - accept_cycle[accept_cycle.size()-2]),
                32'(PERIOD));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect on the second WAIT cycle discards the fetch from 0.
    doReset(1'b1);
    exp_q.push_back(32'h18);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h18);
    runUntilAccepted(1, 1'b1, 30);
    checkOutput("midwait_valid_count", 32'(valid_cycles), 32'd1);

    // Redirect in the very cycle WAIT completes: captured word never becomes valid.
    doReset(1'b1);
    exp_q.push_back(32'h40);
    repeat (LATENCY) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("late_redirect_valid", {31'b0, instr_valid}, 32'd0);
    runUntilAccepted(1, 1'b1, 30);

    // Redirect with fetch disabled only moves the PC.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4C);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fe0_redirect_idle", 32'(valid_cycles), 32'd1);
    checkOutput("fe0_addr_hold", imem_address, 32'h40);

    // Redirect and accept together in HOLD: 0x4C consumed once, then 0x28.
    exp_q.push_back(32'h4C);
    exp_q.push_back(32'h28);
    waitValid(1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h28);
    checkOutput("valid_drop_on_redirect", {31'b0, instr_valid}, 32'd0);
    runUntilAccepted(accepted + 1, 1'b1, 30);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    held_addr = imem_address;
    saved_vc  = valid_cycles;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1002);
    checkOutput("misalign_fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("fault_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, (i == 5), 32'h0);
    checkOutput("fault_no_fetch", 32'(valid_cycles), 32'(saved_vc));
    checkOutput("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    checkOutput("fault_addr_hold", imem_address, held_addr);
    #2 reset = 1'b1;
    #1;
    checkOutput("fault_async_clear", {31'b0, fetch_fault}, 32'd0);
    @(negedge clock);
    doReset(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFC);
    checkOutput("range_last_ok", {31'b0, fetch_fault}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1000);
    checkOutput("range_fault", {31'b0, fetch_fault}, 32'd1);
`else
    // PC wrap and misaligned target rounding.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    runUntilAccepted(accepted + 2, 1'b1, 40);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1002);
    exp_q.push_back(32'h1000);
    runUntilAccepted(accepted + 1, 1'b1, 30);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fault_tied_low", {31'b0, fetch_fault}, 32'd0);
`endif
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between clock edges while a word is held.
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20);
    waitValid(1'b1, 1'b0, 20);
    checkOutput("pre_reset_instr", instr_out, 32'h3210_0020);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("async_instr", instr_out, 32'h0);
    checkOutput("async_pc", pc_out, 32'h0);
    checkOutput("async_addr", imem_address, 32'h0);
    checkOutput("async_fault", {31'b0, fetch_fault}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    checkOutput("extra_accepts", 32'(extra), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Program-counter and fetch sequencer directly upstream of the 4 KB instruction memory. Drives the memory address, waits a fixed latency for the word, and captures it. Presents the instruction and its PC to decode through a valid/ready handshake. Accepts branch/jump redirects from execute at any point.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
MEM_LATENCY, 5, cycles from address presentation to instr_in being valid (range 1..255)
MEM_WORDS, 1024, instruction memory depth in words; used for range check

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
fetch_enable  input  1  1 = allowed to start new fetches; 0 = idle after current fetch
imem_address  output  32  address to instruction memory (byte address, word aligned)
instr_in  input  32  instruction word returned by memory
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  new PC when redirect_valid=1
instr_out  output  32  fetched instruction to decode
pc_out  output  32  address instr_out was fetched from
instr_valid  output  1  instr_out/pc_out valid
instr_ready  input  1  decode accepts when instr_valid && instr_ready
fetch_fault  output  1  sticky fault flag (only with optional feature)

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC; imem_address=RESET_PC; instr_out=0; pc_out=0; instr_valid=0; fetch_fault=0; wait counter=0; state=IDLE.
- States: IDLE, WAIT, HOLD, FAULT.
- IDLE: if fetch_enable=1, drive imem_address=pc, clear counter, go WAIT. Otherwise remain in IDLE.
- WAIT:
  - imem_address held stable at pc; counter increments each cycle.
  - When counter==MEM_LATENCY-1: capture instr_in into instr_out and pc into pc_out; set instr_valid=1; pc<=pc+4; go HOLD.
- HOLD: instr_valid=1 with outputs stable until instr_ready=1. On accept: instr_valid=0 next cycle, go IDLE.
- Latency and throughput:
  - First instr_valid appears MEM_LATENCY+1 cycles after reset deassertion, given fetch_enable=1.
  - Steady-state throughput is one instruction per MEM_LATENCY+2 cycles with ready held high.
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFFFFFC -> 32'h00000000 without error.
- Redirect, any of IDLE/WAIT/HOLD:
  - pc<=redirect_target; counter cleared; in-flight fetch discarded.
  - instr_valid<=0 next cycle; go IDLE, re-issuing next cycle if fetch_enable=1.
- Redirect and accept in same cycle: the accept counts (decode took the word), then the redirect applies as above.
- Redirect in the same cycle WAIT completes: the redirect wins; the captured word is discarded and instr_valid stays 0.
- fetch_enable=0 during WAIT/HOLD: the current fetch completes and is held; no new fetch starts.
- Redirect while fetch_enable=0: pc updates; state stays IDLE.
- No combinational path from instr_ready or redirect_valid to any output.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect_target with bits[1:0]!=0, or >= MEM_WORDS*4, sets fetch_fault=1 (sticky until reset) and drops instr_valid next cycle. State goes FAULT; no further fetches or redirects are honoured until reset. imem_address holds its last value.
- Not defined: redirect_target bits[1:0] are forced to 0 when loaded into pc; no range check is done; fetch_fault is tied 0; the FAULT state is absent.

Test Plan:
- Reset/first fetch: reset held 3 cycles, then fetch_enable=1, ready=1, MEM_LATENCY=5, memory returns 32'h32100000 at 0 -> instr_valid rises 6 cycles after reset release; instr_out=32'h32100000, pc_out=0, imem_address=0 throughout WAIT.
- Sequential stream: ready=1 for 4 instructions -> pc_out sequence 0,4,8,C; instr_valid pulses 1 cycle each, spaced 7 cycles apart.
- Backpressure: ready=0 for 10 cycles while valid -> instr_out/pc_out stable, imem_address unchanged; ready=1 -> accepted once; next fetch at pc+4.
- Redirect mid-WAIT: redirect_valid with target 32'h18 on WAIT cycle 2 -> no instr_valid for the old PC; next valid has pc_out=32'h18.
- Redirect plus accept in HOLD at pc_out=32'h4C, target 32'h28 -> the 0x4C word is consumed once; next pc_out=32'h28.
- Fault: with FETCH_ALIGN_CHECK_EN, target 32'h1002 -> fetch_fault=1 next cycle, no further instr_valid; async reset mid-sequence -> all outputs return to reset values immediately. Without the macro, the same target -> next pc_out=32'h1000.
